uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_ctrl_if.sv | 14 +
 rtl/uart_rx_fifo.sv | 63 ++++++
 rtl/uart_rx_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and CPB limits for the UART receive controller.
package uart_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_CPB    = 2'd2,
    ADDR_CTRL   = 2'd3
  } reg_addr_e;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_BRK       = 3;
  localparam int unsigned ST_TIMEOUT   = 4;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 8;

  localparam int unsigned CTRL_RX_EN   = 0;
  localparam int unsigned CTRL_DATA_IE = 1;
  localparam int unsigned CTRL_ERR_IE  = 2;
  localparam int unsigned CTRL_W       = 3;

  localparam logic [DATA_W-1:0] CPB_MIN = 32'd2;
  localparam logic [DATA_W-1:0] TIMEOUT_BITS = 32'd10;

  // Sticky error flags, ordered to line up with STATUS bits 4..2
  typedef struct packed {
    logic timeout;
    logic brk;
    logic overrun;
  } sticky_t;

  function automatic logic [DATA_W-1:0] clamp_cpb(input logic [DATA_W-1:0] v);
    return (v < CPB_MIN) ? CPB_MIN : v;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Register bus between a host master and the UART receive controller.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic              cs;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output cs, output wen, output addr, output wdata, input rdata);
  modport slave  (input cs, input wen, input addr, input wdata, output rdata);

endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received data; head byte is visible on dout without a read latency.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO, STATUS/CPB/CTRL registers and level interrupt.
// Define UART_RX_TIMEOUT_EN to add the idle-timeout counter and STATUS.timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] DEFAULT_CPB = 32'd434
) (
  input  logic          clk,
  input  logic          resetn,
  uart_rx_ctrl_if.slave bus,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          rx_break,
  output logic          rx_en,
  output logic [31:0]   cycles_per_bit,
  output logic          irq
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] cpb_q, cpb_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  sticky_t           sticky_q, sticky_d, sticky_set, sticky_clr;

  logic              rd_en, wr_en, rx_take;
  logic              push, pop, push_fire, pop_fire;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        count_sat;
  logic [DATA_W-1:0] status_word;
  logic              tmo_set;
  reg_addr_e         addr;

  assign addr    = reg_addr_e'(bus.addr);
  assign rd_en   = bus.cs & ~bus.wen;
  assign wr_en   = bus.cs & bus.wen;
  assign rx_take = rx_valid & ctrl_q[CTRL_RX_EN];

  assign pop       = rd_en & (addr == ADDR_DATA);
  assign push      = rx_take & ~rx_break;
  assign pop_fire  = pop & ~fifo_empty;
  assign push_fire = push & (~fifo_full | pop_fire);

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (rx_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

`ifdef UART_RX_TIMEOUT_EN
  logic [31:0] idle_q, idle_d, tmo_limit;

  assign tmo_limit = cpb_q * TIMEOUT_BITS;

  // Idle counter parks at the limit so timeout fires only once per idle period
  always_comb begin
    idle_d  = idle_q;
    tmo_set = 1'b0;
    if (push_fire || pop_fire || fifo_empty) begin
      idle_d = '0;
    end else if (idle_q < tmo_limit) begin
      idle_d  = idle_q + 32'd1;
      tmo_set = (idle_d == tmo_limit);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) idle_q <= '0;
    else         idle_q <= idle_d;
  end
`else
  assign tmo_set = 1'b0;
`endif

  assign count_sat = (32'(fifo_count) > 32'd255) ? 8'hFF : 8'(fifo_count);

  always_comb begin
    status_word                             = '0;
    status_word[ST_NOT_EMPTY]               = ~fifo_empty;
    status_word[ST_FULL]                    = fifo_full;
    status_word[ST_OVERRUN]                 = sticky_q.overrun;
    status_word[ST_BRK]                     = sticky_q.brk;
    status_word[ST_TIMEOUT]                 = sticky_q.timeout;
    status_word[ST_COUNT_LSB +: ST_COUNT_W] = count_sat;
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins
  always_comb begin
    sticky_set         = '0;
    sticky_set.overrun = push & fifo_full & ~pop_fire;
    sticky_set.brk     = rx_take & rx_break;
    sticky_set.timeout = tmo_set;
    sticky_clr         = '0;
    if (wr_en && (addr == ADDR_STATUS)) begin
      sticky_clr = sticky_t'(bus.wdata[ST_TIMEOUT:ST_OVERRUN]);
    end
    sticky_d = sticky_t'((sticky_q & ~sticky_clr) | sticky_set);
  end

  always_comb begin
    cpb_d  = cpb_q;
    ctrl_d = ctrl_q;
    if (wr_en) begin
      case (addr)
        ADDR_CPB:  cpb_d  = clamp_cpb(bus.wdata);
        ADDR_CTRL: ctrl_d = bus.wdata[CTRL_W-1:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (addr)
        ADDR_DATA:   rdata_d = fifo_empty ? '0 : DATA_W'(fifo_dout);
        ADDR_STATUS: rdata_d = status_word;
        ADDR_CPB:    rdata_d = cpb_q;
        ADDR_CTRL:   rdata_d = DATA_W'(ctrl_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q  <= '0;
      cpb_q    <= DEFAULT_CPB;
      ctrl_q   <= '0;
      sticky_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      cpb_q    <= cpb_d;
      ctrl_q   <= ctrl_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.rdata      = rdata_q;
  assign rx_en          = ctrl_q[CTRL_RX_EN];
  assign cycles_per_bit = cpb_q;
  assign irq            = (ctrl_q[CTRL_DATA_IE] & ~fifo_empty)
                        | (ctrl_q[CTRL_ERR_IE] & (sticky_q.overrun | sticky_q.brk | sticky_q.timeout));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table plus hand-written overrun, break, reset and timeout sequences.
module tb_uart_rx_ctrl;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CPB    = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  typedef struct {
    logic        cs;
    logic        wen;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        rxb;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_break;
  logic        rx_en;
  logic [31:0] cycles_per_bit;
  logic        irq;

  int          n_checks = 0;
  int          n_errors = 0;
  int          row = 0;
  logic [31:0] sb_q [$];
  vec_t        tbl [$];

  uart_rx_ctrl_if bus_if ();

  uart_rx_ctrl #(.DEPTH(16), .DEFAULT_CPB(32'd434)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .bus            (bus_if),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_break       (rx_break),
    .rx_en          (rx_en),
    .cycles_per_bit (cycles_per_bit),
    .irq            (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic cs, input logic wen, input logic [1:0] a,
                              input logic [31:0] wd, input logic rxv, input logic [7:0] rxd,
                              input logic rxb, input logic [31:0] e);
    vec_t v;
    v.cs = cs; v.wen = wen; v.addr = a; v.wdata = wd;
    v.rxv = rxv; v.rxd = rxd; v.rxb = rxb; v.exp_rd = e;
    v.chk_irq = 1'b0; v.exp_irq = 1'b0;
    return v;
  endfunction

  function automatic vec_t rd(input logic [1:0] a, input logic [31:0] e);
    return mk(1'b1, 1'b0, a, 32'd0, 1'b0, 8'd0, 1'b0, e);
  endfunction

  function automatic vec_t wr(input logic [1:0] a, input logic [31:0] d);
    return mk(1'b1, 1'b1, a, d, 1'b0, 8'd0, 1'b0, 32'd0);
  endfunction

  function automatic vec_t rx(input logic [7:0] d, input logic b);
    return mk(1'b0, 1'b0, A_DATA, 32'd0, 1'b1, d, b, 32'd0);
  endfunction

  function automatic vec_t idle();
    return mk(1'b0, 1'b0, A_DATA, 32'd0, 1'b0, 8'd0, 1'b0, 32'd0);
  endfunction

  function automatic vec_t wi(input vec_t v, input logic e);
    vec_t r;
    r = v;
    r.chk_irq = 1'b1;
    r.exp_irq = e;
    return r;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s #%0d: got 0x%08h expected 0x%08h", nm, idx, got, exp);
    end
  endtask

  // Drive one row for a cycle; expected rdata is queued now and retired once the DUT registers it
  task automatic apply(input vec_t v);
    logic [31:0] exp;
    bus_if.cs    = v.cs;
    bus_if.wen   = v.wen;
    bus_if.addr  = v.addr;
    bus_if.wdata = v.wdata;
    rx_valid     = v.rxv;
    rx_data      = v.rxd;
    rx_break     = v.rxb;
    sb_q.push_back((v.cs && !v.wen) ? v.exp_rd : 32'd0);
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0;
    bus_if.wen = 1'b0;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard #%0d: got empty queue expected one entry", row);
    end else begin
      exp = sb_q.pop_front();
      check("rdata", row, bus_if.rdata, exp);
    end
    if (v.chk_irq) check("irq", row, 32'(irq), 32'(v.exp_irq));
    row++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Register map, single byte path, CPB clamping, CTRL masking, rx_en gating, ordering
    tbl.push_back(wi(rd(A_CPB, 32'd434), 1'b0));
    tbl.push_back(wi(rd(A_STATUS, 32'h0), 1'b0));
    tbl.push_back(rd(A_CTRL, 32'h0));
    tbl.push_back(rd(A_DATA, 32'h0));
    tbl.push_back(wi(wr(A_CTRL, 32'h3), 1'b0));
    tbl.push_back(wi(rx(8'h41, 1'b0), 1'b1));
    tbl.push_back(wi(rd(A_STATUS, 32'h0101), 1'b1));
    tbl.push_back(wi(rd(A_DATA, 32'h41), 1'b0));
    tbl.push_back(wi(rd(A_STATUS, 32'h0), 1'b0));
    tbl.push_back(rd(A_CTRL, 32'h3));
    tbl.push_back(wr(A_CPB, 32'd0));
    tbl.push_back(rd(A_CPB, 32'd2));
    tbl.push_back(wr(A_CPB, 32'd1));
    tbl.push_back(rd(A_CPB, 32'd2));
    tbl.push_back(wr(A_CPB, 32'd100));
    tbl.push_back(rd(A_CPB, 32'd100));
    tbl.push_back(wi(wr(A_CTRL, 32'hFFFF_FFFF), 1'b0));
    tbl.push_back(wi(rd(A_CTRL, 32'h7), 1'b0));
    tbl.push_back(wr(A_CTRL, 32'h0));
    tbl.push_back(rx(8'h55, 1'b0));
    tbl.push_back(rd(A_STATUS, 32'h0));
    tbl.push_back(wr(A_CTRL, 32'h1));
    tbl.push_back(rx(8'hA5, 1'b0));
    tbl.push_back(rx(8'h3C, 1'b0));
    tbl.push_back(rd(A_STATUS, 32'h0201));
    tbl.push_back(rd(A_DATA, 32'hA5));
    tbl.push_back(rd(A_DATA, 32'h3C));
    tbl.push_back(rd(A_DATA, 32'h0));
    tbl.push_back(rd(A_STATUS, 32'h0));
    tbl.push_back(rx(8'h11, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, A_DATA, 32'd0, 1'b1, 8'h22, 1'b0, 32'h11));
    tbl.push_back(rd(A_STATUS, 32'h0101));
    tbl.push_back(rd(A_DATA, 32'h22));
    tbl.push_back(mk(1'b1, 1'b0, A_DATA, 32'd0, 1'b1, 8'h33, 1'b0, 32'h0));
    tbl.push_back(rd(A_DATA, 32'h33));
    tbl.push_back(mk(1'b0, 1'b1, A_CTRL, 32'h0, 1'b0, 8'd0, 1'b0, 32'h0));
    tbl.push_back(rd(A_CTRL, 32'h1));
    tbl.push_back(mk(1'b0, 1'b0, A_CPB, 32'h0, 1'b0, 8'd0, 1'b0, 32'h0));

    bus_if.cs = 1'b0; bus_if.wen = 1'b0; bus_if.addr = 2'd0; bus_if.wdata = 32'd0;
    rx_valid = 1'b0; rx_data = 8'd0; rx_break = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    check("reset_rdata", 0, bus_if.rdata, 32'h0);
    check("reset_irq", 0, 32'(irq), 32'h0);
    check("reset_rx_en", 0, 32'(rx_en), 32'h0);
    check("reset_cpb_out", 0, cycles_per_bit, 32'd434);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    check("rx_en_on", row, 32'(rx_en), 32'h1);
    check("cpb_out", row, cycles_per_bit, 32'd100);

    // Overrun: 17 bytes into 16 slots, oldest 16 survive in order
    for (int i = 0; i < 17; i++) apply(rx(8'(i), 1'b0));
    apply(rd(A_STATUS, 32'h1007));
    for (int i = 0; i < 16; i++) apply(rd(A_DATA, 32'(i)));
    apply(rd(A_STATUS, 32'h0004));
    apply(wr(A_STATUS, 32'h4));
    apply(rd(A_STATUS, 32'h0));

    // Full FIFO with simultaneous push and pop: no overrun, count held
    for (int i = 0; i < 16; i++) apply(rx(8'(8'h80 + i), 1'b0));
    apply(rd(A_STATUS, 32'h1003));
    apply(mk(1'b1, 1'b0, A_DATA, 32'd0, 1'b1, 8'hEE, 1'b0, 32'h80));
    apply(rd(A_STATUS, 32'h1003));
    for (int i = 1; i < 16; i++) apply(rd(A_DATA, 32'(8'h80 + i)));
    apply(rd(A_DATA, 32'hEE));
    apply(rd(A_STATUS, 32'h0));

    // Break: no push, sticky brk survives a same-cycle W1C and an unrelated W1C
    apply(wr(A_CTRL, 32'h5));
    apply(wi(rx(8'h99, 1'b1), 1'b1));
    apply(wi(rd(A_STATUS, 32'h0008), 1'b1));
    apply(wi(mk(1'b1, 1'b1, A_STATUS, 32'h8, 1'b1, 8'h77, 1'b1, 32'h0), 1'b1));
    apply(rd(A_STATUS, 32'h0008));
    apply(wr(A_STATUS, 32'h4));
    apply(rd(A_STATUS, 32'h0008));
    apply(wi(wr(A_STATUS, 32'h8), 1'b0));
    apply(wi(rd(A_STATUS, 32'h0), 1'b0));

    // Reset in the middle of buffered traffic
    apply(rx(8'h01, 1'b0));
    apply(rx(8'h02, 1'b0));
    apply(rx(8'h03, 1'b0));
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("midreset_rdata", row, bus_if.rdata, 32'h0);
    check("midreset_rx_en", row, 32'(rx_en), 32'h0);
    check("midreset_irq", row, 32'(irq), 32'h0);
    check("midreset_cpb_out", row, cycles_per_bit, 32'd434);
    apply(rd(A_STATUS, 32'h0));
    apply(rd(A_DATA, 32'h0));
    apply(rd(A_CTRL, 32'h0));
    apply(rd(A_CPB, 32'd434));

`ifdef UART_RX_TIMEOUT_EN
    // Timeout fires exactly 40 cycles after the push with CPB=4, and only once
    apply(wr(A_CTRL, 32'h5));
    apply(wr(A_CPB, 32'd4));
    apply(rd(A_CPB, 32'd4));
    apply(rx(8'h5A, 1'b0));
    for (int i = 0; i < 39; i++) apply(wi(idle(), 1'b0));
    apply(wi(idle(), 1'b1));
    apply(wi(rd(A_STATUS, 32'h0111), 1'b1));
    apply(wr(A_STATUS, 32'h10));
    apply(wi(rd(A_STATUS, 32'h0101), 1'b0));
    for (int i = 0; i < 50; i++) apply(wi(idle(), 1'b0));
    apply(rd(A_DATA, 32'h5A));
    apply(wr(A_CPB, 32'd0));
    apply(rd(A_CPB, 32'd2));
`else
    // Without the timeout feature STATUS bit4 never sets, however long a byte waits
    apply(wr(A_CTRL, 32'h5));
    apply(wr(A_CPB, 32'd2));
    apply(rx(8'h5A, 1'b0));
    for (int i = 0; i < 30; i++) apply(wi(idle(), 1'b0));
    apply(wi(rd(A_STATUS, 32'h0101), 1'b0));
    apply(rd(A_DATA, 32'h5A));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
